vc_input_port: RTL and testbench

// - Parametrised per-port input unit for the next-generation mesh router.
// - One instance per physical input link; a router has PORT_NUM instances.
// - Holds VC_NUM independent virtual-channel FIFOs of depth BUFFER_SIZE.
// - Generates per-VC on/off backpressure and VC-allocatable status toward upstream.
// - Presents each VC's head flit to the switch allocator / crossbar.

---
 rtl/vc_input_port.sv | 197 +++++++++++++++++++
 tb/tb_vc_input_port.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_input_port.sv
// vc_input_port
//   Per-link input unit of the mesh router. Holds VC_NUM virtual-channel FIFOs
//   (depth BUFFER_SIZE, first-word-fall-through), tracks one packet per VC
//   with a small FSM, and produces upstream flow-control status.
//
//   Optional feature: define ON_OFF_HYSTERESIS_EN to give on_off_o separate
//   fall (OFF_THRESH) and rise (ON_THRESH) levels. Without it on_off_o is a
//   single threshold compare against OFF_THRESH.
//
// Ports
//   clk, rst       clock (rising edge) and asynchronous active-low reset
//   data_i         incoming flit payload
//   vc_i           target VC of incoming flit
//   head_i/tail_i  flit type (both set = single-flit packet)
//   valid_i        incoming flit valid
//   rd_en_i        per-VC pop request from the switch allocator
//   data_o         head flit of each VC, VC v at [v*FLIT_W +: FLIT_W]
//   tail_o         head flit of VC v is a tail
//   valid_o        VC v non-empty
//   count_o        occupancy of each VC, VC v at [v*CW +: CW]
//   on_off_o       upstream may send on VC v
//   allocatable_o  VC v idle, may take a new packet
//   error_o        sticky protocol-error flag per VC
module vc_input_port #(
  parameter int unsigned FLIT_W      = 32,
  parameter int unsigned VC_NUM      = 2,
  parameter int unsigned BUFFER_SIZE = 8,
  parameter int unsigned OFF_THRESH  = 2,
  parameter int unsigned ON_THRESH   = 4,
  localparam int unsigned VCW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int unsigned CW  = $clog2(BUFFER_SIZE) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_W-1:0]        data_i,
  input  logic [VCW-1:0]           vc_i,
  input  logic                     head_i,
  input  logic                     tail_i,
  input  logic                     valid_i,
  input  logic [VC_NUM-1:0]        rd_en_i,
  output logic [VC_NUM*FLIT_W-1:0] data_o,
  output logic [VC_NUM-1:0]        tail_o,
  output logic [VC_NUM-1:0]        valid_o,
  output logic [VC_NUM*CW-1:0]     count_o,
  output logic [VC_NUM-1:0]        on_off_o,
  output logic [VC_NUM-1:0]        allocatable_o,
  output logic [VC_NUM-1:0]        error_o
);

  localparam int unsigned PW = CW - 1;
  localparam logic [CW-1:0] FullLvl = CW'(BUFFER_SIZE);
  localparam logic [CW-1:0] OffLvl  = CW'(OFF_THRESH);
`ifdef ON_OFF_HYSTERESIS_EN
  localparam logic [CW-1:0] OnLvl   = CW'(ON_THRESH);
`endif

  // Elaboration-time parameter sanity checks.
  if (VC_NUM < 1) begin : g_bad_vc_num
    $error("VC_NUM must be >= 1");
  end
  if (BUFFER_SIZE < 2 || (BUFFER_SIZE & (BUFFER_SIZE - 1)) != 0) begin : g_bad_depth
    $error("BUFFER_SIZE must be a power of two >= 2");
  end
  if (OFF_THRESH >= ON_THRESH || ON_THRESH > BUFFER_SIZE) begin : g_bad_thresh
    $error("thresholds must satisfy OFF_THRESH < ON_THRESH <= BUFFER_SIZE");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDrain
  } pkt_state_e;

  // A VC index that does not map to a real VC is charged to VC0's error flag.
  logic vc_in_range;
  logic bad_vc;

  assign vc_in_range = 32'(vc_i) < VC_NUM;
  assign bad_vc      = valid_i && !vc_in_range;

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    localparam logic [VCW-1:0] VcId  = VCW'(v);
    localparam bit             IsVc0 = (v == 0);

    // Each entry holds {tail, payload}; the head bit is only needed by the FSM.
    logic [FLIT_W:0] mem_q [BUFFER_SIZE];
    logic [FLIT_W:0] head_flit;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] free_d;
    pkt_state_e    state_q, state_d, state_wr;
    logic          alloc_q;
    logic          on_off_q, on_off_d;
    logic          err_q, err_d;

    logic wr_req;
    logic rd_ok;
    logic full;
    logic proto_ok;
    logic wr_ok;

    assign head_flit = mem_q[rd_ptr_q];

    always_comb begin
      wr_req   = valid_i && vc_in_range && (vc_i == VcId);
      full     = (count_q == FullLvl);
      rd_ok    = rd_en_i[v] && (count_q != '0);
      proto_ok = 1'b0;
      state_wr = state_q;

      // Which flit types the packet FSM accepts, and where an accepted write leads.
      case (state_q)
        StIdle: begin
          proto_ok = head_i;
          state_wr = tail_i ? StDrain : StRecv;
        end
        StRecv: begin
          proto_ok = !head_i;
          state_wr = tail_i ? StDrain : StRecv;
        end
        default: begin
          // StDrain: nothing may be written until the tail leaves.
        end
      endcase

      // A full VC still accepts a write when the same cycle pops a flit.
      wr_ok = wr_req && proto_ok && (!full || rd_ok);

      state_d = state_q;
      if (wr_ok) begin
        state_d = state_wr;
      end else if (state_q == StDrain && rd_ok && head_flit[FLIT_W]) begin
        state_d = StIdle;
      end

      count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
      wr_ptr_d = wr_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = rd_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
      free_d   = FullLvl - count_d;

`ifdef ON_OFF_HYSTERESIS_EN
      on_off_d = on_off_q;
      if (free_d <= OffLvl) begin
        on_off_d = 1'b0;
      end else if (free_d >= OnLvl) begin
        on_off_d = 1'b1;
      end
`else
      on_off_d = (free_d > OffLvl);
`endif

      err_d = err_q
            | (rd_en_i[v] && (count_q == '0))
            | (wr_req && !proto_ok)
            | (wr_req && proto_ok && full && !rd_ok)
            | (IsVc0 && bad_vc);
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        state_q  <= StIdle;
        alloc_q  <= 1'b1;
        on_off_q <= 1'b1;
        err_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        state_q  <= state_d;
        alloc_q  <= (state_d == StIdle);
        on_off_q <= on_off_d;
        err_q    <= err_d;
      end
    end

    // Storage is not reset; valid_o masks stale contents.
    always_ff @(posedge clk) begin
      if (wr_ok) begin
        mem_q[wr_ptr_q] <= {tail_i, data_i};
      end
    end

    assign data_o[v*FLIT_W +: FLIT_W] = head_flit[FLIT_W-1:0];
    assign tail_o[v]                  = head_flit[FLIT_W];
    assign valid_o[v]                 = (count_q != '0);
    assign count_o[v*CW +: CW]        = count_q;
    assign on_off_o[v]                = on_off_q;
    assign allocatable_o[v]           = alloc_q;
    assign error_o[v]                 = err_q;
  end

endmodule

// File: tb/tb_vc_input_port.sv
// Testbench for vc_input_port (VC_NUM=2, BUFFER_SIZE=8, OFF=2, ON=4).
// Accepted writes push {tail, data} into a per-VC expected queue; a negedge
// monitor pops and compares whenever a VC is popped while non-empty.
module tb_vc_input_port;

  localparam int unsigned FW = 32;
  localparam int unsigned VN = 2;
  localparam int unsigned BS = 8;

`ifdef ON_OFF_HYSTERESIS_EN
  localparam bit HystEn = 1'b1;
`else
  localparam bit HystEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] data_i;
  logic [0:0]    vc_i;
  logic          head_i;
  logic          tail_i;
  logic          valid_i;
  logic [1:0]    rd_en_i;
  logic [63:0]   data_o;
  logic [1:0]    tail_o;
  logic [1:0]    valid_o;
  logic [7:0]    count_o;
  logic [1:0]    on_off_o;
  logic [1:0]    allocatable_o;
  logic [1:0]    error_o;

  always #5 clk = ~clk;

  vc_input_port #(
    .FLIT_W     (FW),
    .VC_NUM     (VN),
    .BUFFER_SIZE(BS),
    .OFF_THRESH (2),
    .ON_THRESH  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .vc_i         (vc_i),
    .head_i       (head_i),
    .tail_i       (tail_i),
    .valid_i      (valid_i),
    .rd_en_i      (rd_en_i),
    .data_o       (data_o),
    .tail_o       (tail_o),
    .valid_o      (valid_o),
    .count_o      (count_o),
    .on_off_o     (on_off_o),
    .allocatable_o(allocatable_o),
    .error_o      (error_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] exp_q0 [$];
  logic [32:0] exp_q1 [$];
  logic [32:0] e0;
  logic [32:0] e1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock of stimulus; called and returns at posedge+1.
  task automatic step(input logic wv, input logic [0:0] vc, input logic h, input logic t,
                      input logic [31:0] d, input logic [1:0] rd, input logic acc);
    valid_i = wv;
    vc_i    = vc;
    head_i  = h;
    tail_i  = t;
    data_i  = d;
    rd_en_i = rd;
    if (wv && acc) begin
      if (vc == 1'b1) exp_q1.push_back({t, d});
      else            exp_q0.push_back({t, d});
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    head_i  = 1'b0;
    tail_i  = 1'b0;
    rd_en_i = 2'b00;
  endtask

  task automatic wr(input logic [0:0] vc, input logic h, input logic t, input logic [31:0] d,
                    input logic acc);
    step(1'b1, vc, h, t, d, 2'b00, acc);
  endtask

  task automatic pop(input logic [1:0] rd);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, rd, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},  32'(valid_o),       32'h0);
    check({tag, "_count"},  32'(count_o),       32'h0);
    check({tag, "_error"},  32'(error_o),       32'h0);
    check({tag, "_on_off"}, 32'(on_off_o),      32'h3);
    check({tag, "_alloc"},  32'(allocatable_o), 32'h3);
  endtask

  // Asynchronous reset asserted between clock edges; outputs checked before any edge.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs(tag);
    exp_q0.delete();
    exp_q1.delete();
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a pop happens at the next edge when rd_en and valid are both high.
  always @(negedge clk) begin
    if (rst) begin
      if (rd_en_i[0] && valid_o[0]) begin
        if (exp_q0.size() == 0) begin
          check("vc0_pop_unexpected", 32'(valid_o[0]), 32'h0);
        end else begin
          e0 = exp_q0.pop_front();
          check("vc0_data", data_o[31:0], e0[31:0]);
          check("vc0_tail", 32'(tail_o[0]), 32'(e0[32]));
        end
      end
      if (rd_en_i[1] && valid_o[1]) begin
        if (exp_q1.size() == 0) begin
          check("vc1_pop_unexpected", 32'(valid_o[1]), 32'h0);
        end else begin
          e1 = exp_q1.pop_front();
          check("vc1_data", data_o[63:32], e1[31:0]);
          check("vc1_tail", 32'(tail_o[1]), 32'(e1[32]));
        end
      end
    end
  end

  initial begin
    rst     = 1'b0;
    data_i  = '0;
    vc_i    = '0;
    head_i  = 1'b0;
    tail_i  = 1'b0;
    valid_i = 1'b0;
    rd_en_i = 2'b00;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_reset_outputs("reset_idle");

    // 4-flit packet on VC1: H, B, B, T, then drain.
    wr(1'b1, 1'b1, 1'b0, 32'hA1, 1'b1);
    check("vc1_alloc_after_head", 32'(allocatable_o[1]), 32'h0);
    check("vc1_valid_after_head", 32'(valid_o[1]), 32'h1);
    wr(1'b1, 1'b0, 1'b0, 32'hA2, 1'b1);
    wr(1'b1, 1'b0, 1'b0, 32'hA3, 1'b1);
    wr(1'b1, 1'b0, 1'b1, 32'hA4, 1'b1);
    check("vc1_count4", 32'(count_o[7:4]), 32'd4);
    for (int i = 0; i < 3; i++) pop(2'b10);
    check("vc1_alloc_before_tail_pop", 32'(allocatable_o[1]), 32'h0);
    pop(2'b10);
    check("vc1_alloc_after_tail_pop", 32'(allocatable_o[1]), 32'h1);
    check("vc1_empty", 32'(valid_o[1]), 32'h0);

    // Fill VC0 with 8 flits of an open packet; on_off drops once free <= 2.
    for (int i = 1; i <= 8; i++) begin
      wr(1'b0, (i == 1), 1'b0, 32'h100 + 32'(i), 1'b1);
      check($sformatf("vc0_on_off_fill%0d", i), 32'(on_off_o[0]), (i <= 5) ? 32'd1 : 32'd0);
    end
    check("vc0_count_full", 32'(count_o[3:0]), 32'd8);

    // Same-cycle read and write while full, enough to wrap both pointers.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h200 + 32'(i), 2'b01, 1'b1);
    check("vc0_count_rw_full", 32'(count_o[3:0]), 32'd8);
    check("vc0_error_rw_full", 32'(error_o[0]), 32'h0);
    check("vc0_on_off_rw_full", 32'(on_off_o[0]), 32'h0);

    // Overflow: write to full VC0 without a read.
    wr(1'b0, 1'b0, 1'b0, 32'hDEAD, 1'b0);
    check("vc0_error_overflow", 32'(error_o[0]), 32'h1);
    check("vc0_count_overflow", 32'(count_o[3:0]), 32'd8);

    // Async reset in the middle of an open packet.
    do_reset("reset_midpkt");

    // on_off_o thresholds while draining.
    wr(1'b0, 1'b1, 1'b0, 32'h300, 1'b1);
    for (int i = 1; i <= 5; i++) wr(1'b0, 1'b0, 1'b0, 32'h300 + 32'(i), 1'b1);
    check("vc0_count6", 32'(count_o[3:0]), 32'd6);
    check("vc0_on_off_at6", 32'(on_off_o[0]), 32'h0);
    pop(2'b01);
    check("vc0_on_off_at5", 32'(on_off_o[0]), HystEn ? 32'd0 : 32'd1);
    pop(2'b01);
    check("vc0_on_off_at4", 32'(on_off_o[0]), 32'h1);
    check("vc0_count4", 32'(count_o[3:0]), 32'd4);
    for (int i = 0; i < 4; i++) pop(2'b01);
    check("vc0_empty_open_pkt", 32'(valid_o[0]), 32'h0);
    check("vc0_alloc_open_pkt", 32'(allocatable_o[0]), 32'h0);
    wr(1'b0, 1'b0, 1'b1, 32'h3FF, 1'b1);
    check("vc0_alloc_drain", 32'(allocatable_o[0]), 32'h0);
    pop(2'b01);
    check("vc0_alloc_after_tail", 32'(allocatable_o[0]), 32'h1);

    // Single-flit packet, then a write while draining is rejected.
    wr(1'b0, 1'b1, 1'b1, 32'h400, 1'b1);
    check("vc0_alloc_single", 32'(allocatable_o[0]), 32'h0);
    check("vc0_count_single", 32'(count_o[3:0]), 32'd1);
    wr(1'b0, 1'b1, 1'b0, 32'h401, 1'b0);
    check("vc0_error_drain_write", 32'(error_o[0]), 32'h1);
    check("vc0_count_drain_write", 32'(count_o[3:0]), 32'd1);
    pop(2'b01);
    check("vc0_alloc_single_popped", 32'(allocatable_o[0]), 32'h1);
    check("vc0_empty_single", 32'(valid_o[0]), 32'h0);

    // Head write while VC1 is receiving.
    wr(1'b1, 1'b1, 1'b0, 32'h500, 1'b1);
    check("vc1_error_before", 32'(error_o[1]), 32'h0);
    wr(1'b1, 1'b1, 1'b0, 32'h501, 1'b0);
    check("vc1_error_head_in_recv", 32'(error_o[1]), 32'h1);
    check("vc1_count_head_in_recv", 32'(count_o[7:4]), 32'd1);
    check("vc1_alloc_head_in_recv", 32'(allocatable_o[1]), 32'h0);
    do_reset("reset_again");

    // Underflow on empty VC1 only flags VC1.
    pop(2'b10);
    check("underflow_error", 32'(error_o), 32'h2);
    check("underflow_count", 32'(count_o), 32'h0);

    check("sb_vc0_drained", 32'(exp_q0.size()), 32'd0);
    check("sb_vc1_drained", 32'(exp_q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
